branch_sequencer: RTL and testbench
===================================

Name: branch_sequencer

Overview:
- Multi-cycle instruction sequencer for the KGP-RISC datapath.
- Owns the PC and the architectural flag register (sign, carry, zero).
- Drives a handshaked instruction fetch, then pulses decode and execute phases.
- Resolves conditional jumps from the registered flags and selects the next PC: branch target or PC+4.

Parameters:
- ADDR_W, 32, width of PC and instruction-memory address.
- RESET_PC, 0, PC value loaded on reset.
- CNT_W, 16, width of branch statistics counters (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  leave IDLE and begin fetching at current PC
- imem_req  out  1  fetch request, held until acknowledged
- imem_addr  out  ADDR_W  fetch address (equals pc)
- imem_ack  in  1  fetch complete; imem_data valid this cycle
- imem_data  in  32  fetched instruction
- instr  out  32  latched instruction register
- instr_valid  out  1  one-cycle pulse in DECODE
- exec_en  out  1  high throughout EXECUTE
- exec_done  in  1  datapath finished current instruction
- flag_we  in  1  qualifies flag update, sampled with exec_done
- alu_sign, alu_carry, alu_zero  in  1 each  ALU flag outputs
- branch_target  in  ADDR_W  jump target from datapath, sampled in RESOLVE
- pc  out  ADDR_W  program counter
- taken  out  1  one-cycle pulse in RESOLVE when the jump is taken
- halted  out  1  high in HALT
- flags  out  3  registered {sign, carry, zero}

Behaviour:
- Reset: state=IDLE; pc=RESET_PC; instr=0; flags=0; imem_req, instr_valid, exec_en, taken and halted all 0. Reset dominates all other inputs in every state, including mid-fetch; imem_req is low the cycle after rst.
- IDLE: start=1 moves to FETCH. In all other states start is ignored.
- FETCH: imem_req=1, imem_addr=pc.
  - On imem_ack: instr<=imem_data, then go to DECODE.
  - imem_ack outside FETCH is ignored.
- DECODE: single cycle with instr_valid=1.
  - If opcode=OP_HALT, go to HALT. Otherwise go to EXECUTE.
- EXECUTE: exec_en=1 until exec_done.
  - On exec_done with flag_we=1: flags<={alu_sign,alu_carry,alu_zero}.
  - Then go to RESOLVE.
- RESOLVE: single cycle. The condition is evaluated on the registered flags, which include any update from this instruction's EXECUTE.
  - Taken: pc<={branch_target[ADDR_W-1:2],2'b00} and taken=1.
  - Otherwise: pc<=pc+4, modulo 2^ADDR_W (wrap to 0, no error).
  - Then go to FETCH.
- Jump conditions by opcode:
  - OP_BR: always taken.
  - OP_BLTZ: sign.
  - OP_BZ: zero.
  - OP_BNZ: !zero.
  - OP_BCY: carry.
  - OP_BNCY: !carry.
  - Any other opcode is never taken.
- HALT: halted=1 and pc frozen until rst; start has no effect.
- Minimum latency per instruction, with same-cycle imem_ack and exec_done: 4 cycles (FETCH, DECODE, EXECUTE, RESOLVE).

Optional Feature:
- Macro BRANCH_STATS_EN.
- Defined:
  - Outputs taken_cnt and not_taken_cnt (CNT_W each), reset to 0.
  - In RESOLVE, for jump opcodes only, increment taken_cnt or not_taken_cnt.
  - Both counters saturate at all-ones.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package kgp_pkg holds:
  - opcode localparams: OP_BR=6'b000110, OP_BLTZ=6'b000111, OP_BZ=6'b001000, OP_BNZ=6'b001001, OP_BCY=6'b001101, OP_BNCY=6'b001110, OP_HALT=6'b111111;
  - the state encoding: IDLE, FETCH, DECODE, EXECUTE, RESOLVE, HALT;
  - the opcode field position instr[31:26].
- One combinational sub-module, branch_cond.
  - Inputs: opcode and the three registered flags.
  - Outputs: is_jump and take.
  - Instantiated once in branch_sequencer.

Test Plan:
- Reset then start, instr=32'h0000_0000 (non-jump), ack and exec_done immediate → pc 0→4 after 4 cycles; taken=0; imem_req low during DECODE, EXECUTE and RESOLVE.
- ALU op with flag_we=1, alu_zero=1, followed by OP_BZ with branch_target=32'h0000_0103 → pc=32'h0000_0100; taken pulses for one cycle; flags=3'b001.
- flags={sign=0,carry=1,zero=0}, OP_BNCY then OP_BCY, target 32'h40 → first pc=prev+4, second pc=32'h40.
- imem_ack delayed 3 cycles → imem_req held 4 cycles with a stable address; an imem_ack pulse injected during EXECUTE has no effect.
- pc=32'hFFFF_FFFC with a non-jump instruction → pc wraps to 0. OP_HALT → halted=1; start pulses are ignored; rst returns pc to RESET_PC.
- rst asserted in the second FETCH cycle → next cycle state IDLE, imem_req=0, flags=0. With BRANCH_STATS_EN, 3 taken and 2 not-taken jumps → taken_cnt=3, not_taken_cnt=2.

Source files
------------

// File: rtl/kgp_pkg.sv
// Shared definitions for the KGP-RISC sequencer: opcodes, FSM encoding, field positions.
package kgp_pkg;

    localparam logic [5:0] OP_BR   = 6'b000110;
    localparam logic [5:0] OP_BLTZ = 6'b000111;
    localparam logic [5:0] OP_BZ   = 6'b001000;
    localparam logic [5:0] OP_BNZ  = 6'b001001;
    localparam logic [5:0] OP_BCY  = 6'b001101;
    localparam logic [5:0] OP_BNCY = 6'b001110;
    localparam logic [5:0] OP_HALT = 6'b111111;

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StFetch   = 3'd1;
    localparam logic [2:0] StDecode  = 3'd2;
    localparam logic [2:0] StExecute = 3'd3;
    localparam logic [2:0] StResolve = 3'd4;
    localparam logic [2:0] StHalt    = 3'd5;

    localparam int unsigned OPC_MSB = 31;
    localparam int unsigned OPC_LSB = 26;

    // Bit positions inside the {sign, carry, zero} flag register.
    localparam int unsigned FLAG_S = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_Z = 0;

    function automatic logic [5:0] get_opcode(input logic [31:0] ins);
        return ins[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/branch_cond.sv
// Combinational jump-condition decoder: classifies the opcode and evaluates it on the flags.
module branch_cond
    import kgp_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [2:0] flags,
    output logic       is_jump,
    output logic       take
);

    always_comb begin
        is_jump = 1'b1;
        take    = 1'b0;
        case (opcode)
            OP_BR:   take = 1'b1;
            OP_BLTZ: take = flags[FLAG_S];
            OP_BZ:   take = flags[FLAG_Z];
            OP_BNZ:  take = !flags[FLAG_Z];
            OP_BCY:  take = flags[FLAG_C];
            OP_BNCY: take = !flags[FLAG_C];
            default: is_jump = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_sequencer.sv
// Multi-cycle KGP-RISC sequencer owning PC and flags: FETCH, DECODE, EXECUTE, RESOLVE.
// Optional branch statistics counters are built when BRANCH_STATS_EN is defined.
module branch_sequencer
    import kgp_pkg::*;
#(
    parameter int unsigned          ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0,
    parameter int unsigned          CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_data,
    output logic [31:0]       instr,
    output logic              instr_valid,
    output logic              exec_en,
    input  logic              exec_done,
    input  logic              flag_we,
    input  logic              alu_sign,
    input  logic              alu_carry,
    input  logic              alu_zero,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] pc,
    output logic              taken,
    output logic              halted,
`ifdef BRANCH_STATS_EN
    output logic [CNT_W-1:0]  taken_cnt,
    output logic [CNT_W-1:0]  not_taken_cnt,
`endif
    output logic [2:0]        flags
);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic [2:0]        flags_q, flags_d;
    logic              is_jump;
    logic              take;

    branch_cond u_branch_cond (
        .opcode  (get_opcode(instr_q)),
        .flags   (flags_q),
        .is_jump (is_jump),
        .take    (take)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        flags_d = flags_q;
        case (state_q)
            StIdle: begin
                if (start) state_d = StFetch;
            end
            StFetch: begin
                if (imem_ack) begin
                    instr_d = imem_data;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                state_d = (get_opcode(instr_q) == OP_HALT) ? StHalt : StExecute;
            end
            StExecute: begin
                if (exec_done) begin
                    if (flag_we) flags_d = {alu_sign, alu_carry, alu_zero};
                    state_d = StResolve;
                end
            end
            StResolve: begin
                // Target is forced word-aligned; fall-through wraps naturally.
                if (take) pc_d = {branch_target[ADDR_W-1:2], 2'b00};
                else      pc_d = pc_q + ADDR_W'(4);
                state_d = StFetch;
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            flags_q <= flags_d;
        end
    end

    assign imem_req    = (state_q == StFetch);
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = (state_q == StDecode);
    assign exec_en     = (state_q == StExecute);
    assign pc          = pc_q;
    assign taken       = (state_q == StResolve) && take;
    assign halted      = (state_q == StHalt);
    assign flags       = flags_q;

`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] taken_cnt_q, not_taken_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            taken_cnt_q     <= '0;
            not_taken_cnt_q <= '0;
        end else if ((state_q == StResolve) && is_jump) begin
            if (take) begin
                if (taken_cnt_q != '1) taken_cnt_q <= taken_cnt_q + CNT_W'(1);
            end else begin
                if (not_taken_cnt_q != '1) not_taken_cnt_q <= not_taken_cnt_q + CNT_W'(1);
            end
        end
    end

    assign taken_cnt     = taken_cnt_q;
    assign not_taken_cnt = not_taken_cnt_q;

    logic unused_bits;
    assign unused_bits = ^branch_target[1:0];
`else
    logic unused_bits;
    assign unused_bits = ^{branch_target[1:0], is_jump, (CNT_W != 0)};
`endif

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed self-checking bench for branch_sequencer with hand-computed expected values.
module tb_branch_sequencer;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_data;
    logic [31:0]       instr;
    logic              instr_valid;
    logic              exec_en;
    logic              exec_done;
    logic              flag_we;
    logic              alu_sign;
    logic              alu_carry;
    logic              alu_zero;
    logic [ADDR_W-1:0] branch_target;
    logic [ADDR_W-1:0] pc;
    logic              taken;
    logic              halted;
    logic [2:0]        flags;
`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0]  taken_cnt;
    logic [CNT_W-1:0]  not_taken_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    branch_sequencer #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (32'h0000_0000),
        .CNT_W    (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_data     (imem_data),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .exec_en       (exec_en),
        .exec_done     (exec_done),
        .flag_we       (flag_we),
        .alu_sign      (alu_sign),
        .alu_carry     (alu_carry),
        .alu_zero      (alu_zero),
        .branch_target (branch_target),
        .pc            (pc),
        .taken         (taken),
        .halted        (halted),
`ifdef BRANCH_STATS_EN
        .taken_cnt     (taken_cnt),
        .not_taken_cnt (not_taken_cnt),
`endif
        .flags         (flags)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction from FETCH with same-cycle ack and exec_done; returns taken seen in RESOLVE.
    task automatic run_instr(input logic [31:0] data, input logic fw, input logic s,
                             input logic c, input logic z, input logic [31:0] tgt,
                             output logic tk);
        imem_ack  = 1'b1;
        imem_data = data;
        step();
        imem_ack  = 1'b0;
        step();
        exec_done = 1'b1;
        flag_we   = fw;
        alu_sign  = s;
        alu_carry = c;
        alu_zero  = z;
        step();
        exec_done     = 1'b0;
        flag_we       = 1'b0;
        branch_target = tgt;
        tk            = taken;
        step();
    endtask

    logic tk;

    initial begin
        rst = 1'b1; start = 1'b0; imem_ack = 1'b0; imem_data = '0; exec_done = 1'b0;
        flag_we = 1'b0; alu_sign = 1'b0; alu_carry = 1'b0; alu_zero = 1'b0; branch_target = '0;
        step();
        step();
        rst = 1'b0;
        check("reset_pc", pc, 0);
        check("reset_req", imem_req, 0);
        check("reset_flags", flags, 0);
        check("reset_instr", instr, 0);
        check("reset_outs", {instr_valid, exec_en, taken, halted}, 0);
`ifdef BRANCH_STATS_EN
        check("reset_cnts", {taken_cnt, not_taken_cnt}, 0);
`endif

        // Non-jump instruction: pc 0 -> 4 in four cycles.
        start = 1'b1;
        step();
        start = 1'b0;
        check("t1_fetch_req", {imem_req, imem_addr}, {1'b1, 32'h0});
        imem_ack = 1'b1; imem_data = 32'h0000_0000;
        step();
        imem_ack = 1'b0;
        check("t1_decode", {instr_valid, imem_req, exec_en}, 3'b100);
        step();
        check("t1_execute", {instr_valid, imem_req, exec_en}, 3'b001);
        exec_done = 1'b1;
        step();
        exec_done = 1'b0;
        check("t1_resolve", {imem_req, taken, exec_en}, 3'b000);
        check("t1_pc_hold", pc, 32'h0);
        step();
        check("t1_pc", pc, 32'h4);
        check("t1_refetch", imem_req, 1);

        // ALU op sets zero, then BZ to a misaligned target.
        run_instr(32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, tk);
        check("t2_flags", flags, 3'b001);
        check("t2_pc_alu", pc, 32'h8);
        run_instr(32'h2000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0103, tk);
        check("t2_bz_taken", tk, 1);
        check("t2_bz_pc", pc, 32'h100);
        check("t2_taken_pulse", taken, 0);

        // flags = {0,1,0}; BNCY falls through, BCY jumps.
        run_instr(32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, tk);
        check("t3_flags", flags, 3'b010);
        check("t3_pc_alu", pc, 32'h104);
        run_instr(32'h3800_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h40, tk);
        check("t3_bncy_tk", tk, 0);
        check("t3_bncy_pc", pc, 32'h108);
        run_instr(32'h3400_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h40, tk);
        check("t3_bcy_tk", tk, 1);
        check("t3_bcy_pc", pc, 32'h40);
        run_instr(32'h1800_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h44, tk);
        check("t3_br_pc", pc, 32'h44);
        run_instr(32'h1C00_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h80, tk);
        check("t3_bltz_pc", pc, 32'h48);
`ifdef BRANCH_STATS_EN
        check("stats_taken", taken_cnt, 3);
        check("stats_not_taken", not_taken_cnt, 2);
`endif

        // Delayed ack: request held four cycles at a stable address.
        for (int i = 0; i < 4; i++) begin
            check("t4_req_held", {imem_req, imem_addr}, {1'b1, 32'h48});
            if (i == 3) begin
                imem_ack = 1'b1; imem_data = 32'h0000_0000;
            end
            step();
        end
        imem_ack = 1'b0;
        check("t4_decode", instr_valid, 1);
        step();
        imem_ack = 1'b1; imem_data = 32'hFFFF_FFFF;
        step();
        imem_ack = 1'b0;
        check("t4_stray_ack", {exec_en, instr}, {1'b1, 32'h0});
        exec_done = 1'b1;
        step();
        exec_done = 1'b0;
        step();
        check("t4_pc", pc, 32'h4C);

        // Jump to the top of memory, then wrap on fall-through.
        run_instr(32'h1800_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, tk);
        check("t5_top_pc", pc, 32'hFFFF_FFFC);
        run_instr(32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, tk);
        check("t5_wrap_pc", pc, 32'h0);
        run_instr(32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, tk);
        check("t5_pc4", pc, 32'h4);

        // HALT: frozen until reset, start ignored.
        imem_ack = 1'b1; imem_data = 32'hFC00_0000;
        step();
        imem_ack = 1'b0;
        step();
        check("t5_halted", {halted, exec_en, pc}, {2'b10, 32'h4});
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("t5_halt_start", {halted, imem_req, pc}, {2'b10, 32'h4});
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5_rst_pc", {halted, pc}, {1'b0, 32'h0});

        // Reset in the second FETCH cycle.
        start = 1'b1;
        step();
        start = 1'b0;
        run_instr(32'h0000_0000, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0, tk);
        check("t6_flags_set", flags, 3'b111);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_rst_fetch", {imem_req, flags, pc}, {1'b0, 3'b000, 32'h0});
        step();
        check("t6_idle", imem_req, 0);
`ifdef BRANCH_STATS_EN
        check("t6_cnts_clr", {taken_cnt, not_taken_cnt}, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
